// File: rtl/button_debounce_pkg.sv
// Shared types and default timing constants for the push-button conditioning path.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int unsigned CLK_HZ          = 10_000_000;
  localparam int unsigned DEB_CYCLES_DEF  = CLK_HZ / 100;
  localparam int unsigned LONG_CYCLES_DEF = CLK_HZ;

  // Normalise a synchronised pin sample to 1 = pressed.
  function automatic logic pin_to_pressed(input logic pin, input bit active_low);
    return pin ^ active_low;
  endfunction

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Generic 1-bit two-flop synchroniser with a configurable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, and derive press/release/long-press
// strobes plus a wrapping press counter.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = DEB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES    = LONG_CYCLES_DEF,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       long_press,
  output logic [3:0] press_count
);

  localparam int unsigned DW = $clog2(DEB_CYCLES);
  localparam int unsigned HW = $clog2(LONG_CYCLES);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 2);

  logic          pin_sync;
  logic          s;
  btn_state_t    state;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic          long_flag;

  sync_2ff #(
    .RESET_VAL(BTN_ACTIVE_LOW)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_raw),
    .q  (pin_sync)
  );

  assign s = pin_to_pressed(pin_sync, BTN_ACTIVE_LOW);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      dcnt        <= '0;
      hcnt        <= '0;
      long_flag   <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      long_press  <= 1'b0;
      press_count <= '0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      long_press  <= 1'b0;

      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
          end else if (dcnt == DEB_LAST) begin
            state       <= PRESSED;
            hcnt        <= '0;
            btn_press   <= 1'b1;
            btn_level   <= 1'b1;
            press_count <= press_count + 4'd1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end

        PRESSED: begin
          // Strobe on the edge hcnt reaches its last value so it lands
          // LONG_CYCLES-1 edges after btn_press; the flag blocks re-firing.
          if (hcnt != HOLD_LAST) begin
            hcnt <= hcnt + 1'b1;
          end
          if (hcnt == HOLD_FIRE && !long_flag) begin
            long_press <= 1'b1;
            long_flag  <= 1'b1;
          end
          if (!s) begin
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end
        end

        RELEASE_WAIT: begin
          if (s) begin
            state <= PRESSED;
          end else if (dcnt == DEB_LAST) begin
            state       <= IDLE;
            btn_release <= 1'b1;
            btn_level   <= 1'b0;
            long_flag   <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: run-length reference model, segment table,
// directed latency/corner sequences and randomized pin activity.
module tb_button_debounce;

  localparam int DEB  = 8;
  localparam int LONG = 64;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       btn_level;
  logic       btn_press;
  logic       btn_release;
  logic       long_press;
  logic [3:0] press_count;

  button_debounce #(
    .DEB_CYCLES    (DEB),
    .LONG_CYCLES   (LONG),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .long_press (long_press),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: the level flips once s has disagreed with it for DEB+1
  // consecutive edges; hold time accrues only while pressed with no release pending.
  logic       m_p1, m_p2;
  logic       m_level;
  int         m_cnt;
  int         m_hold;
  logic       m_fired;
  logic [3:0] m_pc;
  logic       e_press, e_rel, e_long;

  int cyc = 0;
  int n_press = 0, n_rel = 0, n_long = 0;
  int t_press = -1, t_rel = -1, t_long = -1;

  typedef struct {
    logic       raw;
    logic       rstn;
    int         len;
    logic       exp_level;
    logic [3:0] exp_count;
  } seg_t;

  seg_t segs[10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_step(input logic raw, input logic rstn);
    logic s;
    bit   pre_pressed;
    e_press = 1'b0;
    e_rel   = 1'b0;
    e_long  = 1'b0;
    if (!rstn) begin
      m_p1 = 1'b1; m_p2 = 1'b1;
      m_level = 1'b0; m_cnt = 0; m_hold = 0; m_fired = 1'b0; m_pc = 4'd0;
      return;
    end
    s = (m_p2 == 1'b0);
    pre_pressed = m_level && (m_cnt == 0);
    if (pre_pressed) begin
      if (m_hold < LONG - 1) m_hold++;
      if (m_hold == LONG - 1 && !m_fired) begin
        e_long  = 1'b1;
        m_fired = 1'b1;
      end
    end
    if (s != m_level) begin
      m_cnt++;
      if (m_cnt == DEB + 1) begin
        m_level = s;
        m_cnt   = 0;
        if (s) begin
          e_press = 1'b1;
          m_pc    = m_pc + 4'd1;
          m_hold  = 0;
        end else begin
          e_rel   = 1'b1;
          m_fired = 1'b0;
        end
      end
    end else begin
      m_cnt = 0;
    end
    m_p2 = m_p1;
    m_p1 = raw;
  endtask

  task automatic cycle(input logic raw, input logic rstn);
    btn_raw = raw;
    rst     = rstn;
    @(posedge clk);
    cyc++;
    model_step(raw, rstn);
    @(negedge clk);
    check("outputs{lvl,prs,rel,lng,cnt}",
          int'({btn_level, btn_press, btn_release, long_press, press_count}),
          int'({m_level, e_press, e_rel, e_long, m_pc}));
    if (btn_press)   begin n_press++; t_press = cyc; end
    if (btn_release) begin n_rel++;   t_rel   = cyc; end
    if (long_press)  begin n_long++;  t_long  = cyc; end
  endtask

  task automatic hold(input logic raw, input int n);
    repeat (n) cycle(raw, 1'b1);
  endtask

  initial begin
    int t0, np0, nr0, nl0;

    segs[0] = '{raw: 1'b1, rstn: 1'b1, len: 5,  exp_level: 1'b0, exp_count: 4'd0};
    segs[1] = '{raw: 1'b0, rstn: 1'b1, len: 20, exp_level: 1'b1, exp_count: 4'd1};
    segs[2] = '{raw: 1'b1, rstn: 1'b1, len: 20, exp_level: 1'b0, exp_count: 4'd1};
    segs[3] = '{raw: 1'b0, rstn: 1'b1, len: 5,  exp_level: 1'b0, exp_count: 4'd1};
    segs[4] = '{raw: 1'b1, rstn: 1'b1, len: 15, exp_level: 1'b0, exp_count: 4'd1};
    segs[5] = '{raw: 1'b0, rstn: 1'b1, len: 12, exp_level: 1'b1, exp_count: 4'd2};
    segs[6] = '{raw: 1'b1, rstn: 1'b1, len: 12, exp_level: 1'b0, exp_count: 4'd2};
    segs[7] = '{raw: 1'b0, rstn: 1'b0, len: 2,  exp_level: 1'b0, exp_count: 4'd0};
    segs[8] = '{raw: 1'b0, rstn: 1'b1, len: 15, exp_level: 1'b1, exp_count: 4'd1};
    segs[9] = '{raw: 1'b1, rstn: 1'b1, len: 15, exp_level: 1'b0, exp_count: 4'd1};

    btn_raw = 1'b1;
    rst     = 1'b0;
    repeat (3) cycle(1'b1, 1'b0);
    check("reset_outputs",
          int'({btn_level, btn_press, btn_release, long_press, press_count}), 0);

    for (int i = 0; i < 10; i++) begin
      repeat (segs[i].len) cycle(segs[i].raw, segs[i].rstn);
      check($sformatf("seg%0d_level", i), int'(btn_level), int'(segs[i].exp_level));
      check($sformatf("seg%0d_count", i), int'(press_count), int'(segs[i].exp_count));
    end

    // Clean press and release latency from a fresh reset.
    repeat (2) cycle(1'b1, 1'b0);
    hold(1'b1, 12);
    np0 = n_press; t_press = -1; t0 = cyc + 1;
    hold(1'b0, 20);
    check("press_latency", t_press - t0, 10);
    check("press_single", n_press - np0, 1);
    check("press_level", int'(btn_level), 1);
    check("press_count1", int'(press_count), 1);
    t_rel = -1; t0 = cyc + 1;
    hold(1'b1, 20);
    check("release_latency", t_rel - t0, 10);

    // Bounce: 3-cycle alternation never settles long enough.
    np0 = n_press;
    for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 1'b0 : 1'b1, 3);
    hold(1'b1, 20);
    check("bounce_no_press", n_press - np0, 0);
    check("bounce_level", int'(btn_level), 0);
    check("bounce_count", int'(press_count), 1);

    // Release glitch while held.
    hold(1'b0, 20);
    nr0 = n_rel;
    hold(1'b1, 5);
    hold(1'b0, 20);
    check("glitch_no_release", n_rel - nr0, 0);
    check("glitch_level", int'(btn_level), 1);
    t_rel = -1; t0 = cyc + 1;
    hold(1'b1, 20);
    check("glitch_release_latency", t_rel - t0, 10);
    check("glitch_release_once", n_rel - nr0, 1);

    // Long press.
    nl0 = n_long; nr0 = n_rel; t_press = -1; t_long = -1;
    hold(1'b0, 100);
    check("long_once", n_long - nl0, 1);
    check("long_delay", t_long - t_press, LONG - 1);
    hold(1'b1, 20);
    check("long_no_second", n_long - nl0, 1);
    check("long_release", n_rel - nr0, 1);

    // Counter wrap after 17 presses.
    repeat (2) cycle(1'b1, 1'b0);
    np0 = n_press;
    repeat (17) begin
      hold(1'b0, 14);
      hold(1'b1, 14);
    end
    check("wrap_presses", n_press - np0, 17);
    check("wrap_count", int'(press_count), 1);

    // Reset while held: fresh debounce afterwards.
    hold(1'b0, 20);
    check("pre_reset_level", int'(btn_level), 1);
    repeat (2) cycle(1'b0, 1'b0);
    check("midreset_outputs",
          int'({btn_level, btn_press, btn_release, long_press, press_count}), 0);
    t_press = -1; t0 = cyc + 1;
    hold(1'b0, 20);
    check("post_reset_press_latency", t_press - t0, 10);
    hold(1'b1, 20);

    // Randomized pin activity with occasional resets and long holds.
    for (int i = 0; i < 160; i++) begin
      int r, len;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        repeat ($urandom_range(1, 3)) cycle(1'($urandom_range(0, 1)), 1'b0);
      end else begin
        len = (r < 13) ? $urandom_range(60, 90) : $urandom_range(1, 25);
        hold(1'($urandom_range(0, 1)), len);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Conditions the raw board push-button for the LED pattern stages. It synchronises the pin into the 10 MHz `clk` domain and filters contact bounce with a counter-based state machine. It produces a clean level, single-cycle press/release/long-press strobes, and a wrapping press counter. It sits directly upstream of the LED blinker and drives that block's `push_button` input.

## Interface
- `DEB_CYCLES`, default 100000 — consecutive stable samples needed to accept a change (10 ms at 10 MHz); legal range ≥ 2.
- `LONG_CYCLES`, default 10000000 — cycles held in the pressed state before `long_press` fires (1 s); must be > `DEB_CYCLES`.
- `BTN_ACTIVE_LOW`, default 1 — 1: pin reads 0 when pressed; 0: pin reads 1 when pressed.

Ports (reset is synchronous and active-low, one clock):
- `clk` in 1 — 10 MHz system clock; the only clock.
- `rst` in 1 — synchronous, active-low reset.
- `btn_raw` in 1 — asynchronous button pin.
- `btn_level` out 1 — debounced state, 1 = pressed (polarity-normalised).
- `btn_press` out 1 — one-cycle strobe on an accepted press.
- `btn_release` out 1 — one-cycle strobe on an accepted release.
- `long_press` out 1 — one-cycle strobe, at most once per press.
- `press_count` out 4 — number of accepted presses, modulo 16.

## Operation
- Two-flop synchroniser on `btn_raw`. The XOR with `BTN_ACTIVE_LOW` gives `s` (1 = pressed). Synchroniser flops reset to the released value.
- Debounce counter `dcnt`, width `$clog2(DEB_CYCLES)`. Hold counter `hcnt`, width `$clog2(LONG_CYCLES)`. Both saturate and never wrap.
- States and transitions:
  - IDLE: `s`=1 → PRESS_WAIT, `dcnt`←0.
  - PRESS_WAIT: `s`=0 → IDLE (bounce rejected, no strobe). Otherwise `dcnt`++. At `dcnt`==DEB_CYCLES-1 with `s`=1 → PRESSED, `hcnt`←0, `btn_press` pulse, `press_count`++.
  - PRESSED: `hcnt`++ while below LONG_CYCLES-1. On reaching LONG_CYCLES-1 → `long_press` pulse once and a latched flag is set. `s`=0 → RELEASE_WAIT, `dcnt`←0.
  - RELEASE_WAIT: `s`=1 → PRESSED; `hcnt` and the long flag are kept; no strobe. Otherwise `dcnt`++. At `dcnt`==DEB_CYCLES-1 with `s`=0 → IDLE, `btn_release` pulse, long flag cleared. `hcnt` is frozen during RELEASE_WAIT.
- `btn_level` = 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
- `press_count` wraps 15 → 0 silently.
- Strobes are mutually exclusive by construction. `long_press` and `btn_release` never share a cycle.

## Timing
- All outputs are registered. Reset values: state IDLE, `btn_level`=0, all strobes 0, `press_count`=0, counters 0, long flag 0.
- Reset is sampled only on `clk` edges. Reset mid-press forces IDLE with no strobes. A button still held after reset must be re-debounced and produces a fresh `btn_press`.
- Press latency: pin goes pressed and stays clean from edge E0 → `btn_press`=1 in the cycle following edge E0+DEB_CYCLES+2. The strobe lasts exactly 1 cycle. `btn_level` rises on the same edge.
- Release latency is symmetric: DEB_CYCLES+2 edges after a clean release, `btn_release` goes high for 1 cycle and `btn_level` falls.
- `long_press` fires LONG_CYCLES-1 edges after `btn_press` asserts, provided there is no accepted release in between.
- A glitch shorter than DEB_CYCLES samples resets the debounce attempt fully. There is no partial credit.

## Structure
- Package `button_pkg`:
  - state enum `btn_state_t` {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}
  - default constants `CLK_HZ`=10_000_000, `DEB_CYCLES_DEF`, `LONG_CYCLES_DEF`
- One sub-module, `sync_2ff`: a generic 1-bit two-flop synchroniser with a reset value parameter. It is reused later for other pins.
- The FSM, counters and output registers live in `button_debounce`.

## Test plan
All scenarios use `DEB_CYCLES`=8, `LONG_CYCLES`=64, `BTN_ACTIVE_LOW`=1.
- Clean press: `btn_raw` 1→0 held 20 cycles → single `btn_press` 10 edges after the change, `btn_level`=1, `press_count`=1.
- Bounce: `btn_raw` toggles 0/1 every 3 cycles for 30 cycles, then stays 1 → no strobes, `btn_level` stays 0, `press_count`=0.
- Release glitch: hold pressed, insert a 5-cycle high pulse → `btn_level` stays 1, no `btn_release`. A subsequent clean release gives `btn_release` after 10 edges.
- Long press: hold 100 cycles → exactly one `long_press`, 63 edges after `btn_press`. On release, `btn_release` follows and there is no second `long_press`.
- Wrap: 17 clean press/release pairs → `press_count` reads 1 and 17 `btn_press` strobes are counted.
- Reset mid-press: assert `rst`=0 during PRESSED for 2 cycles while the button is still held → outputs 0 and `press_count`=0. After reset releases, `btn_press` appears 10 edges later.
